scl_clk_gen: RTL and testbench

Programmable, glitch-free bus-clock generator for the I2C/serial master path. It divides the system clock into a 50 %-duty serial clock, using either the standard (100 kHz) or fast (400 kHz) preset, or a custom 16-bit half-period. It adds register readback, edge strobes for the shift logic, SCL clock-stretch hold, and boundary-synchronised reconfiguration. It is written through the same 7-bit address / 8-bit data register bus as the rest of the controller.

---
 rtl/scl_clk_gen.sv | 179 +++++++++++++++++
 tb/tb_scl_clk_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/scl_clk_gen.sv
// rtl/scl_clk_gen.sv - programmable glitch-free serial bus clock generator
//
// Divides clk into a 50%-duty serial clock (standard / fast preset or custom
// half-period), with register access, edge strobes and SCL stretch hold.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   write, read           register strobes
//   address, writedata    register address (7b) and write data (8b)
//   readdata              registered read data
//   scl_in                sensed bus SCL (asynchronous)
//   clk_out               generated serial clock
//   rise_tick, fall_tick  1-cycle strobes coincident with clk_out edges
//   active                generator running
module scl_clk_gen #(
  parameter int CLK_FREQ_KHZ = 50000,
  parameter int STD_KHZ      = 100,
  parameter int FAST_KHZ     = 400,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic       read,
  input  logic [6:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       scl_in,
  output logic       clk_out,
  output logic       rise_tick,
  output logic       fall_tick,
  output logic       active
);

  localparam int T_STD_I  = CLK_FREQ_KHZ / (2 * STD_KHZ) - 1;
  localparam int T_FAST_I = CLK_FREQ_KHZ / (2 * FAST_KHZ) - 1;
  localparam logic [CNT_W-1:0] T_STD  = T_STD_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] T_FAST = T_FAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE    = 1;
  localparam logic [CNT_W-1:0] TWO    = 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [3:0]       ctrl_q, ctrl_d;
  logic [7:0]       div_lo_q, div_lo_d;
  logic [7:0]       div_hi_q, div_hi_d;
  logic [7:0]       readdata_q, readdata_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] t_act_q, t_act_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             scl_s1_q, scl_s2_q;

  logic [15:0]      div_full;
  logic [CNT_W-1:0] n_cust;
  logic [CNT_W-1:0] t_cust;
  logic [CNT_W-1:0] t_sel;
  logic             hold;

  // Register file
  always_comb begin
    ctrl_d   = ctrl_q;
    div_lo_d = div_lo_q;
    div_hi_d = div_hi_q;
    if (write) begin
      case (address)
        7'd0:    ctrl_d   = writedata[3:0];
        7'd1:    div_lo_d = writedata;
        7'd2:    div_hi_d = writedata;
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        7'd0:    readdata_d = {4'b0000, ctrl_q};
        7'd1:    readdata_d = div_lo_q;
        7'd2:    readdata_d = div_hi_q;
        default: readdata_d = 8'h00;
      endcase
    end
  end

  // Terminal selection looks at the post-write register values so that a
  // write landing on a boundary edge already governs the next half-period.
  always_comb begin
    div_full = {div_hi_d, div_lo_d};
    n_cust   = div_full[CNT_W-1:0];
    t_cust   = (n_cust < TWO) ? ONE : (n_cust - ONE);
    case (ctrl_d[2:1])
      2'b00:   t_sel = T_STD;
      2'b01:   t_sel = T_FAST;
      default: t_sel = t_cust;
    endcase
  end

  // A slave holding SCL low during our high phase freezes the count.
  assign hold = ctrl_q[3] && (state_q == S_RUN) && clk_out_q && !scl_s2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t_act_d   = t_act_q;
    clk_out_d = clk_out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b1;
        if (ctrl_d[0]) begin
          state_d = S_RUN;
          t_act_d = t_sel;
        end
      end
      default: begin
        if (!ctrl_d[0]) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          clk_out_d = 1'b1;
          rise_d    = !clk_out_q;
        end else if (hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q == t_act_q) begin
          cnt_d     = '0;
          clk_out_d = !clk_out_q;
          rise_d    = !clk_out_q;
          fall_d    = clk_out_q;
          t_act_d   = t_sel;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      div_lo_q   <= '0;
      div_hi_q   <= '0;
      readdata_q <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      t_act_q    <= '0;
      clk_out_q  <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      div_lo_q   <= div_lo_d;
      div_hi_q   <= div_hi_d;
      readdata_q <= readdata_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t_act_q    <= t_act_d;
      clk_out_q  <= clk_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      scl_s1_q   <= scl_in;
      scl_s2_q   <= scl_s1_q;
    end
  end

  assign readdata  = readdata_q;
  assign clk_out   = clk_out_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign active    = (state_q == S_RUN);

endmodule

// File: tb/tb_scl_clk_gen.sv
// tb/tb_scl_clk_gen.sv - self-checking bench for scl_clk_gen
module tb_scl_clk_gen;

  logic       clk = 1'b0;
  logic       rst, write, read, scl_in;
  logic [6:0] address;
  logic [7:0] writedata, readdata;
  logic       clk_out, rise_tick, fall_tick, active;

  int vecs = 0;
  int miss = 0;

  scl_clk_gen dut (
    .clk(clk), .rst(rst), .write(write), .read(read), .address(address),
    .writedata(writedata), .readdata(readdata), .scl_in(scl_in),
    .clk_out(clk_out), .rise_tick(rise_tick), .fall_tick(fall_tick),
    .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [6:0] a, input logic [7:0] d);
    write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [6:0] a, output logic [7:0] d);
    read = 1'b1; address = a;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  // Leaves the bench on the first negedge where clk_out has freshly become v.
  task automatic sync_to(input logic v);
    int n = 0;
    while (clk_out == v && n < 2000) begin @(negedge clk); n++; end
    while (clk_out != v && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      vecs++; miss++;
      $display("FAIL sync_to: got timeout expected clk_out=%0d", v);
    end
  endtask

  // Counts cycles until clk_out changes, starting from 'start' elapsed cycles.
  task automatic phase_len(input int start, output int n, output int rt, output int ft);
    logic v;
    v = clk_out; n = start; rt = 0; ft = 0;
    while (clk_out == v && n < 2000) begin
      @(negedge clk);
      n++;
      rt += int'(rise_tick);
      ft += int'(fall_tick);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int hi, lo, rt1, ft1, rt2, ft2, bad;

    tbl[0]  = '{1'b0, 7'd0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 7'd1, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 7'd2, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 7'd5, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 7'd1, 8'hA5, 8'hA5};
    tbl[5]  = '{1'b1, 7'd2, 8'h3C, 8'h3C};
    tbl[6]  = '{1'b1, 7'd0, 8'hF8, 8'h08};
    tbl[7]  = '{1'b1, 7'd5, 8'hFF, 8'h00};
    tbl[8]  = '{1'b0, 7'd1, 8'h00, 8'hA5};
    tbl[9]  = '{1'b1, 7'd0, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 7'd1, 8'h00, 8'h00};
    tbl[11] = '{1'b1, 7'd2, 8'h00, 8'h00};

    rst = 1'b1; write = 1'b0; read = 1'b0; scl_in = 1'b1;
    address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_clk_out", int'(clk_out), 1);
    chk("rst_active", int'(active), 0);
    chk("rst_rise", int'(rise_tick), 0);
    chk("rst_fall", int'(fall_tick), 0);
    chk("rst_readdata", int'(readdata), 0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].wdata);
      bus_rd(tbl[i].addr, rd);
      chk($sformatf("reg_vec%0d", i), int'(rd), int'(tbl[i].exp));
    end
    chk("idle_clk_out", int'(clk_out), 1);
    chk("idle_active", int'(active), 0);

    // Standard mode
    bus_wr(7'd0, 8'h01);
    chk("std_active", int'(active), 1);
    chk("std_first_high", int'(clk_out), 1);
    phase_len(0, hi, rt1, ft1);
    phase_len(0, lo, rt2, ft2);
    chk("std_high", hi, 250);
    chk("std_low", lo, 250);
    chk("std_rise_ticks", rt1 + rt2, 1);
    chk("std_fall_ticks", ft1 + ft2, 1);

    // Custom N=3, then clamped N=1 and N=0
    bus_wr(7'd1, 8'h03);
    bus_wr(7'd2, 8'h00);
    bus_wr(7'd0, 8'h05);
    sync_to(1'b0); sync_to(1'b1);
    phase_len(0, hi, rt1, ft1);
    phase_len(0, lo, rt2, ft2);
    chk("cust3_high", hi, 3);
    chk("cust3_low", lo, 3);
    bus_wr(7'd1, 8'h01);
    sync_to(1'b0); sync_to(1'b1);
    phase_len(0, hi, rt1, ft1);
    phase_len(0, lo, rt2, ft2);
    chk("cust1_high", hi, 2);
    chk("cust1_low", lo, 2);
    bus_wr(7'd1, 8'h00);
    sync_to(1'b0); sync_to(1'b1);
    phase_len(0, hi, rt1, ft1);
    phase_len(0, lo, rt2, ft2);
    chk("cust0_high", hi, 2);
    chk("cust0_low", lo, 2);

    // Fast mode, switch to custom N=10 mid half-period (counter = 20)
    bus_wr(7'd1, 8'd10);
    bus_wr(7'd0, 8'h03);
    sync_to(1'b0); sync_to(1'b1);
    repeat (20) @(negedge clk);
    bus_wr(7'd0, 8'h05);
    phase_len(21, hi, rt1, ft1);
    chk("fast_cur_half", hi, 62);
    phase_len(0, lo, rt2, ft2);
    chk("fast_next_low", lo, 10);
    phase_len(0, hi, rt1, ft1);
    chk("fast_next_high", hi, 10);

    // Stretch: N=8, slave holds SCL low from our falling edge until 20 cycles after rise
    bus_wr(7'd1, 8'd8);
    bus_wr(7'd0, 8'h0D);
    sync_to(1'b0); sync_to(1'b1);
    phase_len(0, hi, rt1, ft1);
    chk("str_plain_high", hi, 8);
    scl_in = 1'b0;
    phase_len(0, lo, rt2, ft2);
    chk("str_pre_low", lo, 8);
    repeat (20) @(negedge clk);
    scl_in = 1'b1;
    phase_len(20, hi, rt1, ft1);
    chk("str_held_high", hi, 30);
    chk("str_held_fall_ticks", ft1, 1);
    phase_len(0, lo, rt2, ft2);
    chk("str_post_low", lo, 8);

    // Disable during low phase
    sync_to(1'b0);
    repeat (3) @(negedge clk);
    bus_wr(7'd0, 8'h00);
    chk("dis_clk_out", int'(clk_out), 1);
    chk("dis_rise_tick", int'(rise_tick), 1);
    chk("dis_active", int'(active), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clk_out !== 1'b1 || rise_tick !== 1'b0 || fall_tick !== 1'b0) bad++;
    end
    chk("dis_quiet", bad, 0);

    // Re-enable: first phase high, full length
    bus_wr(7'd0, 8'h05);
    chk("reen_active", int'(active), 1);
    chk("reen_first_high", int'(clk_out), 1);
    phase_len(0, hi, rt1, ft1);
    phase_len(0, lo, rt2, ft2);
    chk("reen_high", hi, 8);
    chk("reen_low", lo, 8);

    // Reset mid-run while clk_out low
    sync_to(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_clk_out", int'(clk_out), 1);
    chk("mrst_active", int'(active), 0);
    chk("mrst_rise", int'(rise_tick), 0);
    chk("mrst_fall", int'(fall_tick), 0);
    chk("mrst_readdata", int'(readdata), 0);
    bus_rd(7'd0, rd);
    chk("mrst_ctrl", int'(rd), 0);
    bus_rd(7'd1, rd);
    chk("mrst_div_lo", int'(rd), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clk_out !== 1'b1 || active !== 1'b0) bad++;
    end
    chk("mrst_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
